// File: rtl/dfd_trace_fifo.sv
// Trace FIFO between the accumulator and the trace sink: stores full-bank pushes
// and drains each one as SLICES narrower words, lowest bytes first, over valid/ready.
module dfd_trace_fifo #(
  parameter int BANK_DATA_WIDTH_IN_BYTES = 32,
  parameter int FIFO_WIDTH_IN_BYTES      = 16,
  parameter int DEPTH                    = 8,
  parameter int THRESHOLD                = 6
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic                                  fifo_push,
  input  logic [BANK_DATA_WIDTH_IN_BYTES*8-1:0] bank_to_fifo_data_out,
  output logic                                  fifo_space_available,
  output logic                                  fifo_threshold,
  input  logic                                  fifo_flush,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [FIFO_WIDTH_IN_BYTES*8-1:0]      out_data,
  output logic                                  fifo_empty,
  output logic [$clog2(DEPTH):0]                fifo_occupancy,
  output logic                                  fifo_overflow,
  input  logic                                  overflow_clear
);

  localparam int SLICES  = BANK_DATA_WIDTH_IN_BYTES / FIFO_WIDTH_IN_BYTES;
  localparam int OUT_W   = FIFO_WIDTH_IN_BYTES * 8;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int SLICE_W = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int OCC_W   = PTR_W + 1;

  logic [SLICES-1:0][OUT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]             wptr;
  logic [PTR_W-1:0]             rptr;
  logic [SLICE_W-1:0]           slice_idx;
  logic [OCC_W-1:0]             occupancy;

  logic full;
  logic push_ok;
  logic pop;
  logic last_slice;
  logic pop_entry;

  // Room is judged on the registered count only; a same-cycle pop never frees a slot.
  assign full       = (occupancy == OCC_W'(DEPTH));
  assign push_ok    = fifo_push && !full && !fifo_flush;
  assign pop        = out_valid && out_ready;
  assign last_slice = (slice_idx == SLICE_W'(SLICES - 1));
  assign pop_entry  = pop && last_slice;

  assign out_valid            = (occupancy != '0);
  assign fifo_empty           = (occupancy == '0);
  assign fifo_space_available = !full;
  assign fifo_threshold       = (occupancy >= OCC_W'(THRESHOLD));
  assign fifo_occupancy       = occupancy;
  assign out_data             = mem[rptr][slice_idx];

  // NOTE: storage has no reset; occupancy alone says which entries are valid, and
  // leaving the array out of the reset lets it map onto plain RAM.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wptr] <= bank_to_fifo_data_out;
  end

  // NOTE: every register here uses <= so all updates see the start-of-cycle state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr      <= '0;
      rptr      <= '0;
      slice_idx <= '0;
      occupancy <= '0;
    end else if (fifo_flush) begin
      wptr      <= '0;
      rptr      <= '0;
      slice_idx <= '0;
      occupancy <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop) begin
        if (last_slice) begin
          slice_idx <= '0;
          rptr      <= rptr + 1'b1;
        end else begin
          slice_idx <= slice_idx + 1'b1;
        end
      end
      if (push_ok && !pop_entry)      occupancy <= occupancy + 1'b1;
      else if (!push_ok && pop_entry) occupancy <= occupancy - 1'b1;
    end
  end

  // A push dropped at full sets the sticky flag; a flushed push is not an overflow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                           fifo_overflow <= 1'b0;
    else if (fifo_push && full && !fifo_flush) fifo_overflow <= 1'b1;
    else if (overflow_clear)                fifo_overflow <= 1'b0;
  end

endmodule

// File: tb/tb_dfd_trace_fifo.sv
// Directed bench for dfd_trace_fifo: a queue-based reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_dfd_trace_fifo;

  localparam int BW     = 32;
  localparam int FW     = 16;
  localparam int DEPTH  = 8;
  localparam int THRESH = 6;
  localparam int SLICES = BW / FW;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              fifo_push;
  logic [BW*8-1:0]   bank_to_fifo_data_out;
  logic              fifo_space_available;
  logic              fifo_threshold;
  logic              fifo_flush;
  logic              out_valid;
  logic              out_ready;
  logic [FW*8-1:0]   out_data;
  logic              fifo_empty;
  logic [3:0]        fifo_occupancy;
  logic              fifo_overflow;
  logic              overflow_clear;

  int n_checks = 0;
  int n_fail   = 0;

  dfd_trace_fifo #(
    .BANK_DATA_WIDTH_IN_BYTES(BW),
    .FIFO_WIDTH_IN_BYTES(FW),
    .DEPTH(DEPTH),
    .THRESHOLD(THRESH)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .fifo_push(fifo_push),
    .bank_to_fifo_data_out(bank_to_fifo_data_out),
    .fifo_space_available(fifo_space_available),
    .fifo_threshold(fifo_threshold),
    .fifo_flush(fifo_flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .fifo_empty(fifo_empty),
    .fifo_occupancy(fifo_occupancy),
    .fifo_overflow(fifo_overflow),
    .overflow_clear(overflow_clear)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of whole entries plus the index of the next slice.
  logic [BW*8-1:0] m_q[$];
  int              m_sl;
  bit              m_ovf;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_sl  = 0;
      m_ovf = 0;
    end else begin
      bit was_full;
      bit set_ovf;
      was_full = (m_q.size() == DEPTH);
      set_ovf  = fifo_push && was_full && !fifo_flush;
      if (fifo_flush) begin
        m_q.delete();
        m_sl = 0;
      end else begin
        if (m_q.size() != 0 && out_ready) begin
          if (m_sl < SLICES - 1) m_sl++;
          else begin
            m_sl = 0;
            void'(m_q.pop_front());
          end
        end
        if (fifo_push && !was_full) m_q.push_back(bank_to_fifo_data_out);
      end
      if (set_ovf) m_ovf = 1;
      else if (overflow_clear) m_ovf = 0;
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      check("cmp_occupancy", fifo_occupancy, m_q.size());
      check("cmp_valid", out_valid, m_q.size() != 0);
      check("cmp_empty", fifo_empty, m_q.size() == 0);
      check("cmp_space", fifo_space_available, m_q.size() < DEPTH);
      check("cmp_threshold", fifo_threshold, m_q.size() >= THRESH);
      check("cmp_overflow", fifo_overflow, m_ovf);
      if (m_q.size() != 0) check("cmp_data", out_data, m_q[0][m_sl*FW*8 +: FW*8]);
    end
  end

  // Advance to just after the next falling edge: outputs of the last rising edge are settled.
  task automatic next();
    @(negedge clock);
    #1;
  endtask

  logic [BW*8-1:0] ent [24];
  logic [BW*8-1:0] a_word;
  int              handshakes;

  always @(posedge clock) if (reset_n && out_valid && out_ready) handshakes++;

  initial begin
    reset_n = 1'b0;
    fifo_push = 1'b0;
    bank_to_fifo_data_out = '0;
    fifo_flush = 1'b0;
    out_ready = 1'b0;
    overflow_clear = 1'b0;
    handshakes = 0;
    a_word = 256'h1f1e1d1c_1b1a1918_17161514_13121110_0f0e0d0c_0b0a0908_07060504_03020100;
    for (int i = 0; i < 24; i++)
      ent[i] = {8{i[7:0] + 8'h40, 8'(i * 3), 8'hc5, 8'(i)}};

    repeat (2) next();
    reset_n = 1'b1;
    check("rst_empty", fifo_empty, 1'b1);
    check("rst_valid", out_valid, 1'b0);
    check("rst_space", fifo_space_available, 1'b1);
    check("rst_threshold", fifo_threshold, 1'b0);
    check("rst_overflow", fifo_overflow, 1'b0);

    // Single push, held under back-pressure, then drained slice by slice.
    fifo_push = 1'b1;
    bank_to_fifo_data_out = a_word;
    next();
    fifo_push = 1'b0;
    check("push_valid", out_valid, 1'b1);
    check("push_occ", fifo_occupancy, 4'd1);
    check("push_lo", out_data, 128'h0f0e0d0c_0b0a0908_07060504_03020100);
    for (int i = 0; i < 3; i++) begin
      next();
      check("hold_lo", out_data, 128'h0f0e0d0c_0b0a0908_07060504_03020100);
    end
    out_ready = 1'b1;
    next();
    check("drain_hi", out_data, 128'h1f1e1d1c_1b1a1918_17161514_13121110);
    check("drain_hi_valid", out_valid, 1'b1);
    next();
    out_ready = 1'b0;
    check("drain_valid", out_valid, 1'b0);
    check("drain_empty", fifo_empty, 1'b1);

    // Fill to threshold and then to full.
    for (int i = 0; i < DEPTH; i++) begin
      fifo_push = 1'b1;
      bank_to_fifo_data_out = ent[i];
      next();
      if (i == THRESH - 2) check("thr_below", fifo_threshold, 1'b0);
      if (i == THRESH - 1) check("thr_at", fifo_threshold, 1'b1);
    end
    fifo_push = 1'b0;
    check("full_space", fifo_space_available, 1'b0);
    check("full_occ", fifo_occupancy, 4'd8);

    // At full: push alongside the final-slice pop is dropped and flagged.
    out_ready = 1'b1;
    next();
    fifo_push = 1'b1;
    bank_to_fifo_data_out = ent[23];
    next();
    fifo_push = 1'b0;
    out_ready = 1'b0;
    check("ovf_set", fifo_overflow, 1'b1);
    check("ovf_occ", fifo_occupancy, 4'd7);
    check("ovf_head", out_data, ent[1][127:0]);
    overflow_clear = 1'b1;
    next();
    overflow_clear = 1'b0;
    check("ovf_clear", fifo_overflow, 1'b0);

    out_ready = 1'b1;
    for (int i = 0; i < 40 && out_valid; i++) next();
    check("drain_all_empty", fifo_empty, 1'b1);

    // Streaming across pointer wrap: one push every other cycle matches the drain rate.
    handshakes = 0;
    for (int i = 0; i < 40; i++) begin
      fifo_push = (i % 2 == 0);
      bank_to_fifo_data_out = ent[i / 2];
      next();
    end
    fifo_push = 1'b0;
    for (int i = 0; i < 10 && out_valid; i++) next();
    check("stream_count", handshakes, 32'd40);
    check("stream_empty", fifo_empty, 1'b1);
    out_ready = 1'b0;

    // Flush mid-entry with a simultaneous push; overflow flag must survive.
    for (int i = 0; i < DEPTH + 1; i++) begin
      fifo_push = 1'b1;
      bank_to_fifo_data_out = ent[i + 8];
      next();
    end
    fifo_push = 1'b0;
    out_ready = 1'b1;
    repeat (7) next();
    out_ready = 1'b0;
    check("pre_flush_occ", fifo_occupancy, 4'd5);
    check("pre_flush_data", out_data, ent[11][255:128]);
    fifo_flush = 1'b1;
    fifo_push = 1'b1;
    next();
    fifo_flush = 1'b0;
    fifo_push = 1'b0;
    check("flush_empty", fifo_empty, 1'b1);
    check("flush_occ", fifo_occupancy, 4'd0);
    check("flush_valid", out_valid, 1'b0);
    check("flush_ovf", fifo_overflow, 1'b1);

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < 3; i++) begin
      fifo_push = 1'b1;
      bank_to_fifo_data_out = ent[i + 16];
      next();
    end
    fifo_push = 1'b0;
    out_ready = 1'b1;
    next();
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_empty", fifo_empty, 1'b1);
    check("arst_occ", fifo_occupancy, 4'd0);
    check("arst_valid", out_valid, 1'b0);
    check("arst_ovf", fifo_overflow, 1'b0);
    next();
    reset_n = 1'b1;
    out_ready = 1'b0;
    next();
    check("post_rst_empty", fifo_empty, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
